alu_flag_stage: RTL



---
 rtl/alu_flag_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_flag_stage.sv
// alu_flag_stage: registered stage after the 64-bit add/sub unit.
// Captures the adder result, keeps the architectural NZCV flags, resolves
// B.cond / CBZ / CBNZ, and holds the result plus branch decision in a
// one-entry valid/ready buffer for the memory stage.
module alu_flag_stage #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] result,
   input  logic             of,
   input  logic             carry,
   input  logic             set_flags,
   input  logic [1:0]       br_type,
   input  logic [3:0]       cond,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_taken,
   output logic [3:0]       flags
);

   localparam logic [1:0] BR_NONE  = 2'd0;
   localparam logic [1:0] BR_COND  = 2'd1;
   localparam logic [1:0] BR_CBZ   = 2'd2;
   localparam logic [1:0] BR_CBNZ  = 2'd3;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_result;
   logic             r_out_taken;
   logic [3:0]       r_flags;

   logic w_accept;
   logic w_zero;
   logic w_cond_true;
   logic w_taken;
   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;

   // The buffer can take a new entry when empty or when it drains this cycle.
   assign in_ready = !r_out_valid | out_ready;
   assign w_accept = in_valid & in_ready & !flush;

   // Zero test spans the full datapath width.
   assign w_zero = (result == '0);

   // B.cond sees the flags as they stand before this transaction updates them.
   assign w_n = r_flags[3];
   assign w_z = r_flags[2];
   assign w_c = r_flags[1];
   assign w_v = r_flags[0];

   // Evaluate the condition code against the current flag register.
   always_comb begin
      // NOTE: default assignment first so every path drives the output and no latch is inferred.
      w_cond_true = 1'b0;
      case (cond)
         4'd0:    w_cond_true = w_z;
         4'd1:    w_cond_true = !w_z;
         4'd2:    w_cond_true = w_c;
         4'd3:    w_cond_true = !w_c;
         4'd4:    w_cond_true = w_n;
         4'd5:    w_cond_true = !w_n;
         4'd6:    w_cond_true = w_v;
         4'd7:    w_cond_true = !w_v;
         4'd8:    w_cond_true = w_c & !w_z;
         4'd9:    w_cond_true = !w_c | w_z;
         4'd10:   w_cond_true = (w_n == w_v);
         4'd11:   w_cond_true = (w_n != w_v);
         4'd12:   w_cond_true = !w_z & (w_n == w_v);
         4'd13:   w_cond_true = w_z | (w_n != w_v);
         default: w_cond_true = 1'b1;   // AL and NV both always execute
      endcase
   end

   // Select the branch decision by branch type.
   always_comb begin
      w_taken = 1'b0;
      case (br_type)
         BR_NONE: w_taken = 1'b0;
         BR_COND: w_taken = w_cond_true;
         BR_CBZ:  w_taken = w_zero;
         BR_CBNZ: w_taken = !w_zero;
         default: w_taken = 1'b0;
      endcase
   end

   // Output buffer and flag register; reset outranks flush, flush outranks accept.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_taken  <= 1'b0;
         r_flags      <= 4'b0000;
      end else begin
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_result <= result;
            r_out_taken  <= w_taken;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_accept && set_flags) begin
            r_flags <= {result[WIDTH-1], w_zero, carry, of};
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_taken  = r_out_taken;
   assign flags      = r_flags;

endmodule
